// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq_ctrl sequencer.
// Contents:
//   state_e      - sequencer FSM states
//   instr_cls_e  - decoded instruction class, selects the EXEC/MEM path
//   OP_*         - 4-bit opcodes carried in IR[7:4]
//   ALU_SRC_*    - operand select encodings
//   ALU_OP_*     - ALU operation encodings
package alu_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsSrl,
        ClsBeq,
        ClsLoad,
        ClsStore,
        ClsHalt,
        ClsIllegal
    } instr_cls_e;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    localparam logic [1:0] ALU_SRC_REG = 2'b00;  // rs1 / rs2
    localparam logic [1:0] ALU_SRC_ACC = 2'b01;  // accbuf / shamt
    localparam logic [1:0] ALU_SRC_IMM = 2'b10;  // rs1 / imm8
    localparam logic [1:0] ALU_SRC_OFS = 2'b11;  // rs2 / offset5

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_OR  = 3'b011;
    localparam logic [2:0] ALU_OP_SRL = 3'b100;

endpackage

// File: rtl/alu_seq_ctrl_decode.sv
// Combinational opcode decoder for alu_seq_ctrl.
// Ports:
//   opcode_i   - IR[7:4]
//   alu_src_o  - operand select for this opcode
//   alu_op_o   - ALU operation for this opcode
//   cls_o      - instruction class steering the sequencer
module alu_seq_ctrl_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0]  opcode_i,
    output logic [1:0]  alu_src_o,
    output logic [2:0]  alu_op_o,
    output instr_cls_e  cls_o
);

    always_comb begin
        alu_src_o = ALU_SRC_REG;
        alu_op_o  = ALU_OP_ADD;
        cls_o     = ClsIllegal;
        unique case (opcode_i)
            OP_ADD:  begin alu_op_o = ALU_OP_ADD; cls_o = ClsAlu; end
            OP_SUB:  begin alu_op_o = ALU_OP_SUB; cls_o = ClsAlu; end
            OP_AND:  begin alu_op_o = ALU_OP_AND; cls_o = ClsAlu; end
            OP_OR:   begin alu_op_o = ALU_OP_OR;  cls_o = ClsAlu; end
            OP_SRL:  begin alu_src_o = ALU_SRC_ACC; alu_op_o = ALU_OP_SRL; cls_o = ClsSrl; end
            OP_ADDI: begin alu_src_o = ALU_SRC_IMM; alu_op_o = ALU_OP_ADD; cls_o = ClsAlu; end
            OP_LW:   begin alu_src_o = ALU_SRC_OFS; alu_op_o = ALU_OP_ADD; cls_o = ClsLoad; end
            OP_SW:   begin alu_src_o = ALU_SRC_OFS; alu_op_o = ALU_OP_ADD; cls_o = ClsStore; end
            // Compare by subtraction; the ALU zero flag resolves the branch.
            OP_BEQ:  begin alu_op_o = ALU_OP_SUB; cls_o = ClsBeq; end
            OP_HALT: cls_o = ClsHalt;
            default: cls_o = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control sequencer for the 8-bit datapath.
// Fetches a 16-bit instruction over a valid/ready handshake, decodes IR[7:4] and steps
// IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, driving one phase per cycle.
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   start_i                    - leave IDLE (level)
//   instr_valid_i, instr_i     - instruction memory data; instr_req_o requests it
//   pc_inc_o, ir_load_o        - single-cycle pulses on the fetch handshake
//   alu_src_o, alu_op_o        - registered operand select / ALU op, updated leaving DECODE
//   acc_load_o, reg_write_o    - accumulator-buffer load / register-file write pulses
//   mem_req_o, mem_we_o        - data memory request (level) and store qualifier
//   mem_ready_i                - data memory done
//   zero_flag_i, branch_take_o - ALU zero result / branch load pulse
//   busy_o, halted_o, fault_o  - status; fault_o is sticky on memory timeout
// Optional: define ALU_SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT and expose the
// sticky illegal_op_o port; otherwise illegal opcodes are NOPs.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT    = 15,
    parameter bit          START_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        instr_valid_i,
    input  logic [15:0] instr_i,
    output logic        instr_req_o,
    output logic        pc_inc_o,
    output logic        ir_load_o,
    output logic [1:0]  alu_src_o,
    output logic [2:0]  alu_op_o,
    output logic        acc_load_o,
    output logic        reg_write_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    input  logic        mem_ready_i,
    input  logic        zero_flag_i,
    output logic        branch_take_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic        fault_o
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_op_o
`endif
);

    localparam logic [3:0] TimeoutLast = 4'(MEM_TIMEOUT - 1);

    state_e     state_q;
    instr_cls_e cls_q;
    logic [15:0] ir_q;
    logic [1:0]  alu_src_q;
    logic [2:0]  alu_op_q;
    logic [3:0]  tmo_cnt_q;
    logic        fault_q;
    logic        auto_started_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        illegal_q;
`endif

    logic [1:0]  dec_src;
    logic [2:0]  dec_op;
    instr_cls_e  dec_cls;

    // Only the opcode nibble steers sequencing; the rest of IR feeds the datapath.
    logic unused_ir;
    assign unused_ir = ^{ir_q[15:8], ir_q[3:0]};

    alu_seq_ctrl_decode u_decode (
        .opcode_i  (ir_q[7:4]),
        .alu_src_o (dec_src),
        .alu_op_o  (dec_op),
        .cls_o     (dec_cls)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cls_q          <= ClsAlu;
            ir_q           <= '0;
            alu_src_q      <= ALU_SRC_REG;
            alu_op_q       <= ALU_OP_ADD;
            tmo_cnt_q      <= '0;
            fault_q        <= 1'b0;
            auto_started_q <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            illegal_q      <= 1'b0;
`endif
        end else begin
            // Auto-start fires only on the first cycle after reset release.
            auto_started_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (start_i || (START_ON_RESET && !auto_started_q)) state_q <= StFetch;
                end
                StFetch: begin
                    if (instr_valid_i) begin
                        ir_q    <= instr_i;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (dec_cls == ClsHalt) begin
                        state_q <= StHalt;
                    end else if (dec_cls == ClsIllegal) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                        illegal_q <= 1'b1;
                        state_q   <= StHalt;
`else
                        state_q   <= StFetch;
`endif
                    end else begin
                        // Select changes only here, on the DECODE -> EXEC transition.
                        alu_src_q <= dec_src;
                        alu_op_q  <= dec_op;
                        cls_q     <= dec_cls;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    tmo_cnt_q <= '0;
                    if (cls_q == ClsLoad || cls_q == ClsStore) state_q <= StMem;
                    else if (cls_q == ClsAlu)                  state_q <= StWb;
                    else                                       state_q <= StFetch;
                end
                StMem: begin
                    // A ready arriving on the last allowed cycle still completes normally.
                    if (mem_ready_i) begin
                        tmo_cnt_q <= '0;
                        state_q   <= (cls_q == ClsLoad) ? StWb : StFetch;
                    end else if (tmo_cnt_q == TimeoutLast) begin
                        fault_q <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 4'd1;
                    end
                end
                StWb:    state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        instr_req_o   = (state_q == StFetch);
        ir_load_o     = (state_q == StFetch) && instr_valid_i;
        pc_inc_o      = (state_q == StFetch) && instr_valid_i;
        acc_load_o    = (state_q == StExec) && (cls_q == ClsSrl);
        branch_take_o = (state_q == StExec) && (cls_q == ClsBeq) && zero_flag_i;
        reg_write_o   = (state_q == StWb);
        mem_req_o     = (state_q == StMem);
        mem_we_o      = (state_q == StMem) && (cls_q == ClsStore);
        busy_o        = (state_q != StIdle) && (state_q != StHalt);
        halted_o      = (state_q == StHalt);
        fault_o       = fault_q;
        alu_src_o     = alu_src_q;
        alu_op_o      = alu_op_q;
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign illegal_op_o = illegal_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: per-instruction expectations are pushed to a
// scoreboard queue when the instruction is presented and popped when it retires.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic        instr_req, pc_inc, ir_load, acc_load, reg_write, mem_req, mem_we;
    logic        branch_take, busy, halted, fault;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .instr_valid_i (instr_valid),
        .instr_i       (instr),
        .instr_req_o   (instr_req),
        .pc_inc_o      (pc_inc),
        .ir_load_o     (ir_load),
        .alu_src_o     (alu_src),
        .alu_op_o      (alu_op),
        .acc_load_o    (acc_load),
        .reg_write_o   (reg_write),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_ready_i   (mem_ready),
        .zero_flag_i   (zero_flag),
        .branch_take_o (branch_take),
        .busy_o        (busy),
        .halted_o      (halted),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        .illegal_op_o  (illegal_op),
`endif
        .fault_o       (fault)
    );

    logic [15:0] outs;
    assign outs = {instr_req, pc_inc, ir_load, alu_src, alu_op, acc_load, reg_write,
                   mem_req, mem_we, branch_take, busy, halted, fault};

    typedef struct {
        logic [1:0] src;
        logic [2:0] op;
        bit         chk_src;
        int         len;
        int         n_ir;
        int         n_pc;
        int         n_rw;
        int         n_acc;
        int         n_br;
        int         n_mem;
        int         n_we;
        bit         halt;
        bit         flt;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one instruction, from the opcode and memory/branch stimulus.
    function automatic exp_t model(input logic [15:0] ins, input int vwait, input int mwait,
                                   input logic zf);
        exp_t e;
        logic [3:0] opc;
        opc = ins[7:4];
        e = '{src: 2'b00, op: 3'b000, chk_src: 1'b1, len: vwait + 2, n_ir: 1, n_pc: 1,
              n_rw: 0, n_acc: 0, n_br: 0, n_mem: 0, n_we: 0, halt: 1'b0, flt: 1'b0};
        case (opc)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                e.op = opc[2:0]; e.len += 2; e.n_rw = 1;
            end
            4'd4: begin e.src = 2'b01; e.op = 3'b100; e.len += 1; e.n_acc = 1; end
            4'd5: begin e.src = 2'b10; e.len += 2; e.n_rw = 1; end
            4'd6: begin
                e.src = 2'b11; e.n_mem = mwait + 1; e.len += 1 + e.n_mem + 1; e.n_rw = 1;
            end
            4'd7: begin
                e.src = 2'b11;
                if (mwait < 0) begin
                    e.n_mem = 15; e.halt = 1'b1; e.flt = 1'b1;
                end else begin
                    e.n_mem = mwait + 1;
                end
                e.n_we = e.n_mem; e.len += 1 + e.n_mem;
            end
            4'd8: begin e.op = 3'b001; e.len += 1; e.n_br = int'(zf); end
            4'd9: begin e.chk_src = 1'b0; e.halt = 1'b1; end
            default: begin
                e.chk_src = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                e.halt = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Entered during the low phase of a FETCH cycle; returns in the low phase of the next
    // FETCH (or HALT) cycle.
    task automatic run_instr(input string tag, input logic [15:0] ins, input int vwait,
                             input int mwait, input logic zf);
        exp_t e, got;
        bit   fetched = 1'b0;
        bit   done = 1'b0;
        int   mcnt = 0;
        sb_q.push_back(model(ins, vwait, mwait, zf));
        got = '{src: 2'b00, op: 3'b000, chk_src: 1'b0, len: 0, n_ir: 0, n_pc: 0, n_rw: 0,
                n_acc: 0, n_br: 0, n_mem: 0, n_we: 0, halt: 1'b0, flt: 1'b0};
        instr = ins;
        zero_flag = zf;
        for (int c = 0; c < 200 && !done; c++) begin
            instr_valid = !fetched && (c == vwait);
            mem_ready   = mem_req && (mwait >= 0) && (mcnt == mwait);
            #1;
            if ((fetched && instr_req) || halted) begin
                done = 1'b1;
            end else begin
                got.len++;
                if (ir_load)     got.n_ir++;
                if (pc_inc)      got.n_pc++;
                if (reg_write)   got.n_rw++;
                if (acc_load)    got.n_acc++;
                if (branch_take) got.n_br++;
                if (mem_req)     begin got.n_mem++; mcnt++; end
                if (mem_we)      got.n_we++;
                if (ir_load)     fetched = 1'b1;
                @(negedge clk);
            end
        end
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        if (!done) check({tag, " retire timeout"}, 32'd0, 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " cycles"}, got.len, e.len);
            check({tag, " ir_load"}, got.n_ir, e.n_ir);
            check({tag, " pc_inc"}, got.n_pc, e.n_pc);
            check({tag, " reg_write"}, got.n_rw, e.n_rw);
            check({tag, " acc_load"}, got.n_acc, e.n_acc);
            check({tag, " branch_take"}, got.n_br, e.n_br);
            check({tag, " mem_req"}, got.n_mem, e.n_mem);
            check({tag, " mem_we"}, got.n_we, e.n_we);
            check({tag, " halted"}, 32'(halted), 32'(e.halt));
            check({tag, " fault"}, 32'(fault), 32'(e.flt));
            if (e.chk_src) begin
                check({tag, " alu_src"}, 32'(alu_src), 32'(e.src));
                check({tag, " alu_op"}, 32'(alu_op), 32'(e.op));
            end
        end
    endtask

    // Leaves the bench in the low phase of the first FETCH cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset outputs", 32'(outs), 32'd0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        check("reset illegal_op", 32'(illegal_op), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle after release", 32'(instr_req), 32'd0);
        @(negedge clk);
        #1;
        check("auto start fetch", 32'(instr_req), 32'd1);
        check("busy in fetch", 32'(busy), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        run_instr("addi", 16'h3550, 2, 0, 1'b0);
        run_instr("add", 16'h1200, 0, 0, 1'b0);
        run_instr("sub", 16'h0012, 1, 0, 1'b0);
        run_instr("and", 16'h0023, 0, 0, 1'b1);
        run_instr("or", 16'h0031, 3, 0, 1'b0);
        run_instr("srl", 16'h0343, 0, 0, 1'b0);
        run_instr("beq_z1", 16'h0080, 0, 0, 1'b1);
        run_instr("beq_z0", 16'h0080, 1, 0, 1'b0);
        run_instr("lw_slow", 16'h0465, 0, 4, 1'b0);
        run_instr("sw_fast", 16'h0172, 0, 0, 1'b0);
        run_instr("sw_edge", 16'h0272, 0, 14, 1'b0);
        run_instr("lw_fast", 16'h0061, 1, 0, 1'b0);
        run_instr("illegal", 16'h00C0, 0, 0, 1'b0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        check("illegal_op set", 32'(illegal_op), 32'd1);
        do_reset();
`else
        run_instr("after_nop", 16'h0500, 0, 0, 1'b0);
`endif

        // Reset while a load is waiting on memory.
        instr = 16'h0060;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        #1;
        check("mem_req before reset", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset mid-mem", 32'(outs), 32'd0);
        do_reset();

        run_instr("sw_timeout", 16'h0070, 0, -1, 1'b0);
        start = 1'b1;
        instr_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("halt sticky", 32'({halted, fault, instr_req, busy, ir_load}), 32'b11000);
        start = 1'b0;
        instr_valid = 1'b0;
        do_reset();

        run_instr("halt_op", 16'h0090, 1, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("halt op stays", 32'({halted, fault, busy}), 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 8-bit datapath.
- Fetches a 16-bit instruction through a valid/ready handshake, decodes it, and drives the 2-bit ALU-source select, ALU op, register-file, accumulator-buffer and data-memory strobes one phase at a time.
- Sits between instruction memory, the ALU-source operand selector, the ALU, the register file and data memory.
- Single owner of ALU_SRC: the select never changes except on a state transition.

Parameters:
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready before abort (4-bit counter).
- START_ON_RESET, 1, 1 = leave IDLE automatically after reset; 0 = wait for start.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begin execution from IDLE
- instr_valid  in  1  instruction memory has data
- instr  in  16  instruction word
- instr_req  out  1  fetch request
- pc_inc  out  1  one-cycle PC increment pulse
- ir_load  out  1  latch instr into IR
- alu_src  out  2  operand select: 00 rs1/rs2, 01 accbuf/shamt, 10 rs1/imm8, 11 rs2/offset5
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 srl
- acc_load  out  1  load accumulator buffer from ALU result
- reg_write  out  1  register-file write strobe
- mem_req  out  1  data memory request
- mem_we  out  1  1 = store, 0 = load (valid with mem_req)
- mem_ready  in  1  data memory done
- zero_flag  in  1  ALU zero result
- branch_take  out  1  one-cycle branch load pulse
- busy  out  1  not in IDLE or HALT
- halted  out  1  in HALT
- fault  out  1  sticky: memory timeout

Behaviour:
- Decode: opcode = IR[7:4].
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 8 BEQ: alu_src 00
  - 4 SRL: alu_src 01, alu_op 100
  - 5 ADDI: alu_src 10
  - 6 LW, 7 SW: alu_src 11, alu_op add
  - 9 HALT
  - 10-15 illegal
- Reset (async, rst_n=0): state IDLE; all outputs 0; alu_src 00; IR cleared; timeout counter 0; fault cleared.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE -> FETCH when start=1, or on the first cycle after reset release if START_ON_RESET=1.
- FETCH: instr_req=1.
  - Stays in FETCH while instr_valid=0.
  - On instr_valid=1: ir_load=1, pc_inc=1 for that cycle, -> DECODE.
- DECODE: one cycle. alu_src and alu_op take the decoded values, registered so they are stable from EXEC onward.
  - HALT opcode -> HALT.
  - Illegal opcode -> FETCH (NOP).
  - All others -> EXEC.
- EXEC: one cycle, ALU evaluates.
  - LW/SW -> MEM.
  - BEQ: branch_take = zero_flag, then -> FETCH.
  - SRL: acc_load=1, -> FETCH.
  - Others -> WB.
- MEM: mem_req=1, mem_we=1 for SW.
  - Held until mem_ready=1, then LW -> WB and SW -> FETCH.
  - The timeout counter increments each waiting cycle. When it reaches MEM_TIMEOUT with no ready: fault=1 (sticky), -> HALT.
  - mem_ready in the same cycle as the timeout wins (completes normally).
- WB: reg_write=1 for one cycle, -> FETCH.
- HALT: halted=1; only rst_n exits. start is ignored.
- Strobes (ir_load, pc_inc, acc_load, reg_write, branch_take) are single-cycle pulses.
- Handshakes:
  - instr_req and mem_req are level-held until their ready/valid is seen.
  - instr_valid outside FETCH and mem_ready outside MEM are ignored.
- Reset mid-MEM or mid-FETCH: requests drop immediately (async), with no partial write strobes.

Optional Feature:
- ALU_SEQ_ILLEGAL_TRAP_EN
  - Defined: illegal opcode in DECODE -> HALT and sets sticky output illegal_op (extra 1-bit port, reset 0).
  - Undefined: illegal opcode is a NOP (DECODE -> FETCH), and the port is absent.

Decomposition:
- Shared package alu_seq_pkg:
  - state enum
  - opcode constants OP_ADD..OP_HALT
  - ALU_SRC_REG/ACC/IMM/OFS constants (00/01/10/11)
  - ALU op codes
- One natural sub-module, alu_seq_decode: combinational opcode -> {alu_src, alu_op, class}. The FSM and timeout counter stay in the top.

Test Plan:
- Reset/start: rst_n low mid-MEM with mem_req=1 -> all outputs 0 asynchronously, state IDLE. Release with START_ON_RESET=1 -> instr_req=1 on the next cycle.
- ADDI: instr=0x3550 (imm 0x35, opcode 5) with instr_valid after 2 wait cycles -> ir_load/pc_inc pulse once, alu_src=10 from EXEC, reg_write pulse in WB. Total 6 cycles from instr_req to next instr_req.
- LW with slow memory: opcode 6, mem_ready after 4 cycles -> alu_src=11, mem_req held 5 cycles with mem_we=0, reg_write one cycle after mem_ready.
- SW timeout: opcode 7, mem_ready never -> after 15 wait cycles fault=1, halted=1. Further start or instr_valid have no effect.
- SRL/BEQ: SRL (opcode 4, shamt 3) -> alu_src=01, acc_load pulse in EXEC, no reg_write. BEQ with zero_flag=1 -> branch_take pulse. With zero_flag=0 -> no pulse.
- Illegal opcode 0xC: macro undefined -> next cycle FETCH, no strobes. Macro defined -> HALT with illegal_op=1.
